// File: rtl/tybec_sched_pkg.sv
// tybec_sched_pkg: shared state encoding and default sizing for the kernel run controller.
package tybec_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;
  localparam int DEF_CNTW = 32;
  localparam int DEF_MAX_INFLIGHT = 64;
  localparam int DEF_IFW = 7;
endpackage

// File: rtl/tybec_credit_cnt.sv
// tybec_credit_cnt: up/down in-flight item counter; credit_ok while below MAX_INFLIGHT.
module tybec_credit_cnt #(
  parameter int MAX_INFLIGHT = 64,
  parameter int IFW = 7
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           inc,
  input  logic           dec,
  output logic [IFW-1:0] inflight,
  output logic           credit_ok
);
  logic [IFW-1:0] cnt_q, cnt_d;
  logic up, dn;
  assign credit_ok = cnt_q < IFW'(MAX_INFLIGHT);
  assign up = inc & credit_ok;
  // a decrement at zero is only honoured when it cancels a simultaneous increment
  assign dn = dec & ((cnt_q != '0) | up);
  assign inflight = cnt_q;
  always_comb cnt_d = (up == dn) ? cnt_q : up ? cnt_q + IFW'(1) : cnt_q - IFW'(1);
  always_ff @(posedge aclk or posedge areset)
    if (areset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tybec_kernel_sched.sv
// tybec_kernel_sched: run controller gating the main kernel handshake, bounding in-flight items, counting a run.
// Optional perf counters enabled by defining TY_SCHED_PERF_EN; otherwise perf_* are tied to zero.
module tybec_kernel_sched
  import tybec_sched_pkg::*;
#(
  parameter int CNTW = DEF_CNTW,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int IFW = DEF_IFW
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            start,
  input  logic [CNTW-1:0] num_items,
  output logic            busy,
  output logic            done,
  output logic [IFW-1:0]  inflight,
  input  logic            s_tvalid,
  output logic            s_tready,
  output logic            k_ivalid,
  input  logic            k_iready,
  input  logic            k_ovalid,
  output logic            k_oready,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [CNTW-1:0] perf_cyc,
  output logic [CNTW-1:0] perf_istall,
  output logic [CNTW-1:0] perf_ostall
);
  sched_state_e state_q, state_d;
  logic [CNTW-1:0] n_q, n_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic credit_ok, in_fire, out_fire, run, act, go;
  assign run = state_q == RUN;
  assign act = run | (state_q == DRAIN);
  assign go = (state_q == IDLE) & start;
  assign s_tready = run & k_iready & credit_ok;
  assign k_ivalid = run & s_tvalid & credit_ok;
  assign k_oready = act & m_tready;
  assign m_tvalid = act & k_ovalid;
  assign in_fire = s_tvalid & s_tready;
  assign out_fire = k_ovalid & k_oready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  tybec_credit_cnt #(.MAX_INFLIGHT(MAX_INFLIGHT), .IFW(IFW)) u_credit (
    .aclk(aclk), .areset(areset), .inc(in_fire), .dec(out_fire), .inflight(inflight), .credit_ok(credit_ok)
  );
  always_comb begin
    state_d = state_q;
    n_d = go ? num_items : n_q;
    in_cnt_d = (go | done) ? '0 : in_cnt_q + CNTW'(in_fire);
    out_cnt_d = (go | done) ? '0 : out_cnt_q + CNTW'(out_fire);
    if (go) state_d = (num_items == '0) ? DONE : RUN;
    else if (done) state_d = IDLE;
    else if (act & out_fire & (out_cnt_q == n_q - CNTW'(1)) & ((state_q == DRAIN) | (in_cnt_q == n_q))) state_d = DONE;
    else if (run & in_fire & (in_cnt_q == n_q - CNTW'(1))) state_d = DRAIN;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= IDLE;
      n_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
`ifdef TY_SCHED_PERF_EN
  logic [CNTW-1:0] pc_q, pc_d, pi_q, pi_d, po_q, po_d;
  always_comb begin
    pc_d = go ? '0 : (act & ~&pc_q) ? pc_q + CNTW'(1) : pc_q;
    pi_d = go ? '0 : (run & s_tvalid & ~s_tready & ~&pi_q) ? pi_q + CNTW'(1) : pi_q;
    po_d = go ? '0 : (act & k_ovalid & ~m_tready & ~&po_q) ? po_q + CNTW'(1) : po_q;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      pc_q <= '0;
      pi_q <= '0;
      po_q <= '0;
    end else begin
      pc_q <= pc_d;
      pi_q <= pi_d;
      po_q <= po_d;
    end
  assign perf_cyc = pc_q;
  assign perf_istall = pi_q;
  assign perf_ostall = po_q;
`else
  assign perf_cyc = '0;
  assign perf_istall = '0;
  assign perf_ostall = '0;
`endif
endmodule
